// File: rtl/ser_rcv_fifo.sv
// ser_rcv_fifo -- serial receive front end with a small byte FIFO.
//
// Purpose:
//   Synchronises the asynchronous rxd line through two flops. Finds start bits and
//   samples each frame in the middle of every bit. Received bytes are queued in a
//   circular FIFO that the ser controller reads through a pop/ready/data handshake.
//   Framing errors and overruns are reported as sticky status flags.
//
// Build option:
//   RCV_PARITY_EN  When defined, frames are 8E1. A PARITY state sits between DATA and
//                  STOP, and a byte is kept only if its stop bit is 1 and its parity
//                  is even. When undefined, frames are 8N1 and no parity logic exists.
//
// Parameters:
//   CLK_DIV_CYCLES   clock cycles per serial bit (must be >= 4)
//   FIFO_DEPTH_LOG2  log2 of the number of FIFO entries (must be >= 1)
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   reset      in   synchronous, active-low reset
//   rd         in   pop the head byte; ignored while ready is 0
//   ready      out  FIFO holds at least one byte
//   data_out   out  head byte of the FIFO, combinational from storage
//   err_clr    in   clears frame_err and overrun
//   frame_err  out  sticky: bad stop bit (or bad parity) seen
//   overrun    out  sticky: good byte arrived while FIFO full with no pop
//   rxd        in   serial input, idle high, asynchronous to clk
module ser_rcv_fifo #(
    parameter int CLK_DIV_CYCLES  = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd,
    output logic       ready,
    output logic [7:0] data_out,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    input  logic       rxd
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int CNT_W = $clog2(CLK_DIV_CYCLES);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef RCV_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic             sync1_q, sync2_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
`ifdef RCV_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             push;
    logic             ferr_set;

    logic [AW:0]      wptr_q, rptr_q;
    logic [7:0]       mem_q [DEPTH];
    logic             frame_err_q, overrun_q;
    logic             empty, full, pop, wr_en, ovr_set;

    logic rx;
    assign rx = sync2_q;

    // Receive FSM: the baud counter is reloaded on every transition and the line is
    // sampled when it reaches zero, which lands in the middle of each bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
`ifdef RCV_PARITY_EN
        par_d    = par_q;
`endif
        push     = 1'b0;
        ferr_set = 1'b0;
        if (state_q == S_IDLE) begin
            if (!rx) begin
                state_d = S_START;
                cnt_d   = HALF_BIT;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = FULL_BIT;
            case (state_q)
                S_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d[bitcnt_q] = rx;
                    if (bitcnt_q == 3'd7) begin
`ifdef RCV_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
`ifdef RCV_PARITY_EN
                S_PARITY: begin
                    par_d   = rx;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    // Leaving at mid-stop-bit lets the next start edge be caught.
                    state_d = S_IDLE;
`ifdef RCV_PARITY_EN
                    if (rx && ((^shift_q ^ par_q) == 1'b0)) push = 1'b1;
                    else                                    ferr_set = 1'b1;
`else
                    if (rx) push = 1'b1;
                    else    ferr_set = 1'b1;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = rd && !empty;
    // When full, a push only fits if the head is popped in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    assign ready     = !empty;
    assign data_out  = mem_q[rptr_q[AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= 3'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q  <= rxd;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            // A set in the same cycle as err_clr takes priority.
            if (ferr_set)     frame_err_q <= 1'b1;
            else if (err_clr) frame_err_q <= 1'b0;
            if (ovr_set)      overrun_q   <= 1'b1;
            else if (err_clr) overrun_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef RCV_PARITY_EN
        par_q   <= par_d;
`endif
        if (wr_en && reset) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

endmodule

// File: tb/tb_ser_rcv_fifo.sv
// tb_ser_rcv_fifo -- directed bench for ser_rcv_fifo with 16 clocks per bit and a
// four-entry FIFO. Frames are generated by a task; inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_ser_rcv_fifo;

    localparam int DIV = 16;
`ifdef RCV_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rd = 1'b0;
    logic       ready;
    logic [7:0] data_out;
    logic       err_clr = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       rxd = 1'b1;

    int total = 0;
    int bad   = 0;

    int   rise_cnt   = 0;
    logic ready_prev = 1'b0;

    ser_rcv_fifo #(.CLK_DIV_CYCLES(DIV), .FIFO_DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .ready     (ready),
        .data_out  (data_out),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rxd       (rxd)
    );

    always #5 clk = ~clk;

    // Counts rising edges of ready as seen at falling clock edges.
    always @(negedge clk) begin
        if (ready === 1'b1 && ready_prev === 1'b0) rise_cnt <= rise_cnt + 1;
        ready_prev <= ready;
    end

    // Sends one frame starting at the current falling edge. stop_v is the stop bit
    // level, par_v the parity bit (parity builds only). With pop_at set, rd is high
    // on exactly the rising edge where the stop bit is sampled.
    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v,
                        input bit pop_at);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        if (PAR) begin
            rxd = par_v;
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_v;
        for (int c = 0; c < DIV; c++) begin
            if (pop_at) rd = (c == 10);
            @(negedge clk);
        end
        rd  = 1'b0;
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        reset = 1'b1;
        repeat (100) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", ready); end
    endtask

    task automatic test_single();
        int r0;
        r0 = rise_cnt;
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (rise_cnt - r0 != 1) begin bad++; $display("FAIL single_rises got=%0d want=1", rise_cnt - r0); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", data_out); end
        pop_one();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_pop_ready got=%b want=0", ready); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ovr_frame_err got=%b want=0", frame_err); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            total++;
            if (ready !== 1'b1 || data_out !== exp) begin
                bad++; $display("FAIL ovr_data%0d got=%b/%h want=1/%h", i, ready, data_out, exp);
            end
            pop_one();
        end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b want=0", ready); end
        clear_err();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    endtask

    task automatic test_frame_err();
        int r0;
        r0 = rise_cnt;
        send(8'h3C, 1'b0, ~^8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b want=1", frame_err); end
        total++; if (ready !== 1'b0 || rise_cnt != r0) begin bad++; $display("FAIL ferr_no_push ready=%b rises=%0d want 0/0", ready, rise_cnt - r0); end
        clear_err();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b want=0", frame_err); end
        r0 = rise_cnt;
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        total++; if (ready !== 1'b0 || rise_cnt != r0) begin bad++; $display("FAIL glitch_no_byte ready=%b want=0", ready); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL glitch_no_err got=%b want=0", frame_err); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1, ^(8'h11 + 8'(i)), 1'b0);
        send(8'h15, 1'b1, ^8'h15, 1'b1);
        send(8'h16, 1'b1, ^8'h16, 1'b1);
        @(negedge clk);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL pp_overrun got=%b want=0", overrun); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h13 + 8'(i);
            total++;
            if (ready !== 1'b1 || data_out !== exp) begin
                bad++; $display("FAIL pp_data%0d got=%b/%h want=1/%h", i, ready, data_out, exp);
            end
            pop_one();
        end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL pp_drained got=%b want=0", ready); end
    endtask

    task automatic test_reset_mid_frame();
        int r0;
        r0 = rise_cnt;
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        total++; if (ready !== 1'b0 || rise_cnt != r0) begin bad++; $display("FAIL midreset_empty ready=%b want=0", ready); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midreset_ferr got=%b want=0", frame_err); end
        send(8'h5A, 1'b1, ^8'h5A, 1'b0);
        @(negedge clk);
        total++; if (ready !== 1'b1 || data_out !== 8'h5A) begin bad++; $display("FAIL midreset_next got=%b/%h want=1/5a", ready, data_out); end
        pop_one();
    endtask

`ifdef RCV_PARITY_EN
    task automatic test_parity();
        send(8'h07, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (ready !== 1'b1 || data_out !== 8'h07) begin bad++; $display("FAIL par_good got=%b/%h want=1/07", ready, data_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL par_good_ferr got=%b want=0", frame_err); end
        pop_one();
        send(8'h07, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL par_bad_ferr got=%b want=1", frame_err); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL par_bad_push got=%b want=0", ready); end
        clear_err();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_push_pop_full();
`ifdef RCV_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
